// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner: off patterns, segment bit order
// and the digit-index width helper.
package seg_pkg;

  // Segment bus is active-low and ordered {a,b,c,d,e,f,g,dp}, a in the MSB.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Widest supported display; narrower instances slice the low DIGITS bits.
  localparam int unsigned MaxDigits = 8;
  localparam logic [MaxDigits-1:0] AN_OFF = '1;

  // Bit positions of the segment bus.
  localparam int unsigned SEG_BIT_A  = 7;
  localparam int unsigned SEG_BIT_G  = 1;
  localparam int unsigned SEG_BIT_DP = 0;

  // Width of a digit index for a display of the given size.
  function automatic int unsigned idx_width(input int unsigned digits);
    return $clog2(digits);
  endfunction

endpackage

// File: rtl/BCD_Encoder.sv
// BCD to active-low {a..g,dp} pattern. Non-decimal codes blank all segments;
// the dp bit is always off here and is overridden by the scanner.
module BCD_Encoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  // Combinational decode of one digit.
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0000001;
      4'd1:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b1001111;
      4'd2:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0010010;
      4'd3:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0000110;
      4'd4:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b1001100;
      4'd5:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0100100;
      4'd6:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0100000;
      4'd7:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0001111;
      4'd8:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0000000;
      4'd9:    seg_o[SEG_BIT_A:SEG_BIT_G] = 7'b0000100;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner. Latches the digit vector
// once per frame, steps one digit per slot, and keeps all anodes off for the
// first DEAD_CYCLES of each slot to avoid ghosting.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking (digit 0 never blanks).
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int unsigned IdxW = idx_width(DIGITS);
  localparam int unsigned CntW = $clog2(REFRESH_DIV);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick_q, tick_d;

  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_bcd;
  logic                cur_dp;
  logic                cur_blank;
  logic [7:0]          enc_seg;
  logic                cnt_last;
  logic                idx_last;
  logic                frame_start;
  logic                lit;

`ifdef SEG_SCAN_LZB_EN
  // A digit blanks when it and every more significant digit are zero.
  always_comb begin
    blank = '0;
    blank[DIGITS-1] = (bcd_q[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = int'(DIGITS) - 2; i >= 1; i--) begin
      blank[i] = blank[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
    blank[0] = 1'b0;
  end
`else
  assign blank = '0;
`endif

  // Select the snapshot fields of the digit currently being scanned.
  always_comb begin
    cur_bcd   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_bcd   = bcd_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = blank[i];
      end
    end
  end

  BCD_Encoder u_bcd_encoder (
    .bcd_i (cur_bcd),
    .seg_o (enc_seg)
  );

  // Next-state for the slot counter, digit index, snapshot and output registers.
  always_comb begin
    cnt_last    = (cnt_q == CntW'(REFRESH_DIV - 1));
    idx_last    = (idx_q == IdxW'(DIGITS - 1));
    frame_start = (cnt_q == '0) && (idx_q == '0);

    cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_last) begin
      idx_d = idx_last ? '0 : idx_q + IdxW'(1);
    end

    bcd_d = frame_start ? bcd_in : bcd_q;
    dp_d  = frame_start ? dp_in  : dp_q;

    lit   = (cnt_q >= CntW'(DEAD_CYCLES)) && !cur_blank;
    an_d  = AN_OFF[DIGITS-1:0];
    seg_d = SEG_OFF;
    if (lit) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        an_d[i] = (idx_q != IdxW'(i));
      end
      seg_d             = enc_seg;
      seg_d[SEG_BIT_DP] = ~cur_dp;
    end

    tick_d = frame_start;
  end

  // State and registered outputs; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      bcd_q  <= '0;
      dp_q   <= '0;
      an_q   <= AN_OFF[DIGITS-1:0];
      seg_q  <= SEG_OFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      bcd_q  <= bcd_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule
